// File: rtl/mig_traffic_arbiter.sv
// Shares one MIG user port between an HDMI read stream and NUM_WR camera write streams.
// Each write channel owns a FRAME_WORDS-word DRAM region. Reads are throttled by the outstanding-request count.
module mig_traffic_arbiter #(
    parameter int NUM_WR        = 2,
    parameter int FRAME_WORDS   = 115200,
    parameter int MAX_CMD_QUEUE = 8,
    parameter int WR_BURST_MAX  = 64,
    localparam int SEL_W        = (NUM_WR > 1) ? $clog2(NUM_WR) : 1
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    // MIG user interface
    output logic [26:0]             app_addr,
    output logic [2:0]              app_cmd,
    output logic                    app_en,
    output logic [127:0]            app_wdf_data,
    output logic                    app_wdf_end,
    output logic                    app_wdf_wren,
    output logic [15:0]             app_wdf_mask,
    output logic                    app_sr_req,
    output logic                    app_ref_req,
    output logic                    app_zq_req,
    input  logic [127:0]            app_rd_data,
    input  logic                    app_rd_data_valid,
    input  logic                    app_rdy,
    input  logic                    app_wdf_rdy,
    input  logic                    init_calib_complete,
    // camera write streams
    input  logic [NUM_WR*128-1:0]   write_axis_data,
    input  logic [NUM_WR-1:0]       write_axis_valid,
    input  logic [NUM_WR-1:0]       write_axis_tlast,
    output logic [NUM_WR-1:0]       write_axis_ready,
    // HDMI read stream
    output logic [127:0]            read_axis_data,
    output logic                    read_axis_valid,
    output logic                    read_axis_tlast,
    input  logic                    read_axis_ready,
    input  logic                    read_axis_af,
    input  logic [SEL_W-1:0]        rd_sel_in,
    output logic                    rd_overflow_out
);

    localparam int CNT_W   = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
    localparam int OUT_W   = $clog2(MAX_CMD_QUEUE + 1);
    localparam int BURST_W = $clog2(WR_BURST_MAX + 1);

    typedef enum logic [1:0] {
        ST_RST,
        ST_WAIT_INIT,
        ST_RD_HDMI,
        ST_WR_CAM
    } state_t;

    state_t             state_reg;
    logic [SEL_W-1:0]   grant_reg;
    logic               granted_once_reg;
    logic [BURST_W-1:0] burst_cnt_reg;
    logic [BURST_W-1:0] burst_next;
    logic [OUT_W-1:0]   outstanding_reg;
    logic [CNT_W-1:0]   rd_req_cnt_reg;
    logic [CNT_W-1:0]   rsp_cnt_reg;
    logic [SEL_W-1:0]   rd_ch_reg;
    logic               rd_overflow_reg;

    logic [CNT_W-1:0]   wr_cnt [NUM_WR];
    logic [127:0]       wr_data_arr [NUM_WR];
    logic [SEL_W-1:0]   rr_base;
    logic [SEL_W-1:0]   rr_pick;
    logic               any_valid;
    logic               grant_valid;
    logic               queue_full;
    logic               rd_can_issue;
    logic               rd_req;
    logic               rd_accept;
    logic               wr_fire;
    logic [26:0]        rd_addr;
    logic [26:0]        wr_addr;

    assign any_valid    = |write_axis_valid;
    assign grant_valid  = write_axis_valid[grant_reg];
    assign queue_full   = outstanding_reg >= OUT_W'(MAX_CMD_QUEUE);
    assign rd_can_issue = !queue_full && !read_axis_af;
    assign rd_req       = (state_reg == ST_RD_HDMI) && rd_can_issue;
    assign rd_accept    = rd_req && app_rdy;
    assign wr_fire      = (state_reg == ST_WR_CAM) && grant_valid && app_rdy && app_wdf_rdy;

    // Saturates so a long visit with reads still blocked cannot wrap the count.
    assign burst_next = burst_cnt_reg +
                        BURST_W'(wr_fire && (burst_cnt_reg < BURST_W'(WR_BURST_MAX)));

    assign rd_addr = 27'((32'(rd_ch_reg) * 32'(FRAME_WORDS) + 32'(rd_req_cnt_reg)) << 3);
    assign wr_addr = 27'((32'(grant_reg) * 32'(FRAME_WORDS) + 32'(wr_cnt[grant_reg])) << 3);

    // Before the first grant the search starts at channel 0.
    assign rr_base = granted_once_reg ? grant_reg : SEL_W'(NUM_WR - 1);

    function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] base, input int k);
        return SEL_W'((int'(base) + k) % NUM_WR);
    endfunction

    always_comb begin
        rr_pick = grant_reg;
        for (int k = NUM_WR; k >= 1; k--) begin
            if (write_axis_valid[rr_idx(rr_base, k)]) begin
                rr_pick = rr_idx(rr_base, k);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WR; gi++) begin : g_wr
            logic [CNT_W-1:0] cnt_reg;

            assign wr_data_arr[gi]      = write_axis_data[gi*128 +: 128];
            assign wr_cnt[gi]           = cnt_reg;
            assign write_axis_ready[gi] = app_rdy && app_wdf_rdy && (state_reg == ST_WR_CAM) &&
                                          (grant_reg == SEL_W'(gi));

            // The tlast beat lands at the current count; the next frame restarts at 0.
            always_ff @(posedge clk_in or negedge rst_n_in) begin
                if (!rst_n_in) begin
                    cnt_reg <= '0;
                end else if (write_axis_valid[gi] && write_axis_ready[gi]) begin
                    if (write_axis_tlast[gi] || (cnt_reg == CNT_W'(FRAME_WORDS - 1))) begin
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_reg        <= ST_RST;
            grant_reg        <= '0;
            granted_once_reg <= 1'b0;
            burst_cnt_reg    <= '0;
        end else begin
            case (state_reg)
                ST_RST: begin
                    state_reg <= ST_WAIT_INIT;
                end
                ST_WAIT_INIT: begin
                    if (init_calib_complete) begin
                        state_reg <= ST_RD_HDMI;
                    end
                end
                ST_RD_HDMI: begin
                    burst_cnt_reg <= '0;
                    if ((queue_full || read_axis_af) && any_valid) begin
                        state_reg        <= ST_WR_CAM;
                        grant_reg        <= rr_pick;
                        granted_once_reg <= 1'b1;
                    end
                end
                ST_WR_CAM: begin
                    burst_cnt_reg <= burst_next;
                    // Leave on the beat that reaches the limit so no extra beat slips out.
                    if (!any_valid ||
                        ((burst_next >= BURST_W'(WR_BURST_MAX)) && rd_can_issue)) begin
                        state_reg <= ST_RD_HDMI;
                    end else if (!grant_valid) begin
                        grant_reg <= rr_pick;
                    end
                end
                default: begin
                    state_reg <= ST_RST;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            outstanding_reg <= '0;
            rd_req_cnt_reg  <= '0;
            rd_ch_reg       <= '0;
            rsp_cnt_reg     <= '0;
            rd_overflow_reg <= 1'b0;
        end else begin
            if (rd_accept && !app_rd_data_valid) begin
                outstanding_reg <= outstanding_reg + 1'b1;
            end else if (!rd_accept && app_rd_data_valid && (outstanding_reg != '0)) begin
                outstanding_reg <= outstanding_reg - 1'b1;
            end

            if (rd_accept) begin
                if (rd_req_cnt_reg == CNT_W'(FRAME_WORDS - 1)) begin
                    rd_req_cnt_reg <= '0;
                    rd_ch_reg      <= rd_sel_in;
                end else begin
                    rd_req_cnt_reg <= rd_req_cnt_reg + 1'b1;
                end
            end

            if (app_rd_data_valid) begin
                if (rsp_cnt_reg == CNT_W'(FRAME_WORDS - 1)) begin
                    rsp_cnt_reg <= '0;
                end else begin
                    rsp_cnt_reg <= rsp_cnt_reg + 1'b1;
                end
            end

            if (app_rd_data_valid && !read_axis_ready) begin
                rd_overflow_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        app_addr     = '0;
        app_cmd      = 3'b000;
        app_en       = 1'b0;
        app_wdf_data = '0;
        app_wdf_wren = 1'b0;
        app_wdf_end  = 1'b0;
        case (state_reg)
            ST_RD_HDMI: begin
                app_en   = rd_req;
                app_cmd  = 3'b001;
                app_addr = rd_addr;
            end
            ST_WR_CAM: begin
                app_en       = wr_fire;
                app_wdf_wren = wr_fire;
                app_wdf_end  = wr_fire;
                app_wdf_data = wr_data_arr[grant_reg];
                app_addr     = wr_addr;
            end
            default: begin
            end
        endcase
    end

    assign app_wdf_mask    = '0;
    assign app_sr_req      = 1'b0;
    assign app_ref_req     = 1'b0;
    assign app_zq_req      = 1'b0;
    assign read_axis_data  = app_rd_data;
    assign read_axis_valid = app_rd_data_valid;
    assign read_axis_tlast = (rsp_cnt_reg == CNT_W'(FRAME_WORDS - 1));
    assign rd_overflow_out = rd_overflow_reg;

endmodule

// File: doc/mig_traffic_arbiter.md
MIG_TRAFFIC_ARBITER -- requirements
Module: mig_traffic_arbiter

Interface
REQ-001 Parameter NUM_WR, default 2: number of write AXIS channels; legal range 1..4.
REQ-002 Parameter FRAME_WORDS, default 115200: 128-bit words per frame region.
REQ-003 Parameter MAX_CMD_QUEUE, default 8: maximum outstanding read requests.
REQ-004 Parameter WR_BURST_MAX, default 64: maximum write beats per WR_CAM visit while reads are pending.
REQ-005 Port clk_in, input, 1: single clock; this is the MIG ui clock.
REQ-006 Port rst_n_in, input, 1: asynchronous, active-low reset.
REQ-007 MIG ports app_addr[26:0], app_cmd[2:0], app_en, app_wdf_data[127:0], app_wdf_end, app_wdf_wren and app_wdf_mask[15:0] are outputs; app_rd_data[127:0], app_rd_data_valid, app_rdy, app_wdf_rdy and init_calib_complete are inputs.
REQ-008 Outputs app_sr_req, app_ref_req and app_zq_req are each 1 bit and tied to 0; app_wdf_mask is tied to 0.
REQ-009 Write AXIS ports are write_axis_data[NUM_WR*128-1:0], write_axis_valid[NUM_WR-1:0] and write_axis_tlast[NUM_WR-1:0] as inputs, and write_axis_ready[NUM_WR-1:0] as an output; channel i occupies slice i.
REQ-010 Read AXIS ports are read_axis_data[127:0], read_axis_valid and read_axis_tlast as outputs, and read_axis_ready and read_axis_af as inputs.
REQ-011 Port rd_sel_in, input, max(1,$clog2(NUM_WR)) bits: selects the channel region for the next read frame.
REQ-012 Port rd_overflow_out, output, 1: sticky flag set when read data is lost.

Function
REQ-013 Region base for channel c SHALL be c*FRAME_WORDS; app_addr SHALL be (base + word counter) << 3, truncated to 27 bits.
REQ-014 Each channel SHALL have a write counter that increments on its handshake, wraps from FRAME_WORDS-1 to 0, and clears to 0 on a handshake carrying tlast (the tlast beat is written at its current count).
REQ-015 The FSM SHALL have states RST, WAIT_INIT, RD_HDMI and WR_CAM; it goes RST->WAIT_INIT unconditionally and WAIT_INIT->RD_HDMI when init_calib_complete=1.
REQ-016 RD_HDMI->WR_CAM SHALL occur when (outstanding>=MAX_CMD_QUEUE or read_axis_af) and any write_axis_valid bit is 1.
REQ-017 WR_CAM->RD_HDMI SHALL occur when no write_axis_valid bit is 1, or when the beats written this visit reach WR_BURST_MAX and outstanding<MAX_CMD_QUEUE and read_axis_af=0.
REQ-018 Grant SHALL be chosen on entry to WR_CAM by round-robin, starting after the last granted channel among valid channels; grant is held until that channel's valid drops, then re-arbitrates inside WR_CAM in the same cycle order.
REQ-019 write_axis_ready[i] SHALL equal app_rdy & app_wdf_rdy & (state==WR_CAM) & (grant==i).
REQ-020 In WR_CAM, app_en, app_wdf_wren and app_wdf_end SHALL equal the granted valid & app_rdy & app_wdf_rdy, with app_cmd=000 and app_wdf_data set to the granted slice.
REQ-021 In RD_HDMI, a read request SHALL be valid when outstanding<MAX_CMD_QUEUE and read_axis_af=0; app_en equals that condition, app_cmd=001, and the request is accepted when app_en & app_rdy.
REQ-022 The read request counter SHALL wrap at FRAME_WORDS-1; the read channel register SHALL load rd_sel_in when the request at count FRAME_WORDS-1 is accepted.
REQ-023 The outstanding counter SHALL be incremented by an accepted request, decremented by app_rd_data_valid, and left unchanged when both occur in the same cycle; it never exceeds MAX_CMD_QUEUE.
REQ-024 read_axis_valid and read_axis_data SHALL be combinational copies of app_rd_data_valid and app_rd_data.
REQ-025 The response counter SHALL increment on app_rd_data_valid and wrap at FRAME_WORDS-1; read_axis_tlast=1 exactly when the response counter equals FRAME_WORDS-1.
REQ-026 rd_overflow_out SHALL be set on app_rd_data_valid & ~read_axis_ready and SHALL be cleared only by reset.
REQ-027 In RST and WAIT_INIT, all MIG command and write outputs SHALL be 0.

Reset
REQ-028 Asserting rst_n_in low SHALL immediately clear every counter, the grant, the read channel register, rd_overflow_out and the burst count, and SHALL force the state to RST.
REQ-029 Reset mid-burst SHALL drop all outstanding accounting; responses arriving after reset are counted from 0.

Verification
REQ-030 Calibration: hold init_calib_complete=0 for 100 cycles -> app_en=0 throughout, then the first read is issued at app_addr=0.
REQ-031 Read throttle: hold app_rdy=1 and return no read data -> exactly 8 requests at app_addr 0,8,...,56, then no further requests until data returns.
REQ-032 Round-robin: NUM_WR=2, both channels valid, channel 0 valid for 3 beats -> channel 0 written at addr 0,8,16, then channel 1 at 921600,921608,...
REQ-033 Burst limit: channel 0 valid continuously with reads pending -> exactly 64 beats, then return to RD_HDMI.
REQ-034 Frame wrap: FRAME_WORDS=16 with rd_sel_in=1 -> tlast on response 15, and the next request goes to app_addr 16<<3=128.
REQ-035 Overflow: read_axis_ready=0 while app_rd_data_valid=1 -> rd_overflow_out=1 until rst_n_in=0.
